// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ctrl: hazard/sequencing control for the 5-stage MIPS pipeline   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pipeline_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [4:0]      ifid_rs,
  input  logic [4:0]      ifid_rt,
  input  logic            idex_dren,
  input  logic [4:0]      idex_rt,
  input  logic            ex_redirect,
  input  logic            exmem_dren,
  input  logic            exmem_dwen,
  input  logic            exmem_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            halt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [1:0] c_RUN    = 2'd0;
  localparam logic [1:0] c_DWAIT  = 2'd1;
  localparam logic [1:0] c_DRAIN  = 2'd2;
  localparam logic [1:0] c_HALTED = 2'd3;

  localparam logic [CNTW-1:0] c_CNT_MAX = {CNTW{1'b1}};

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            r_halt;
  logic [CNTW-1:0] r_stall_cnt;
  logic            w_dmiss;
  logic            w_load_use;
  logic            w_frozen;
  logic            w_stall_cyc;

  assign w_dmiss    = (exmem_dren | exmem_dwen) & ~dhit;
  assign w_load_use = idex_dren & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  // DWAIT holds everything (including a pending redirect) until the data returns
  assign w_frozen   = (r_state == c_DWAIT) & ~dhit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_RUN;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_DRAIN) begin
        r_halt <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_RUN, c_DWAIT: begin
        if (!w_frozen) begin
          if (exmem_halt) begin
            w_next_state = c_DRAIN;
          end else if (w_dmiss) begin
            w_next_state = c_DWAIT;
          end else begin
            w_next_state = c_RUN;
          end
        end
      end
      c_DRAIN:  w_next_state = c_HALTED;
      c_HALTED: w_next_state = c_HALTED;
      default:  w_next_state = c_RUN;
    endcase
  end

  // A flushed latch is still enabled so it loads the bubble on the next edge
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (r_state)
        c_RUN, c_DWAIT: begin
          if (!w_frozen) begin
            if (exmem_halt) begin
              ifid_en     = 1'b1;
              idex_en     = 1'b1;
              exmem_en    = 1'b1;
              memwb_en    = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end else if (!w_dmiss) begin
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
              if (ex_redirect) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
              end else if (w_load_use) begin
                idex_flush = 1'b1;
              end else if (!ihit) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
              end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
              end
            end
          end
        end
        c_DRAIN: begin
          memwb_en = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_stall_cyc = ~pc_en & ((r_state == c_RUN) | (r_state == c_DWAIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_stall_cyc && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_pipeline_ctrl;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] c_RESET   = 8'b00000_111;
  localparam logic [7:0] c_NORMAL  = 8'b11111_000;
  localparam logic [7:0] c_FREEZE  = 8'b00000_000;
  localparam logic [7:0] c_LOADUSE = 8'b00111_010;
  localparam logic [7:0] c_REDIR   = 8'b11111_110;
  localparam logic [7:0] c_IMISS   = 8'b01111_100;
  localparam logic [7:0] c_HALTREQ = 8'b01111_111;
  localparam logic [7:0] c_DRAIN   = 8'b00001_000;
  localparam logic [7:0] c_IDLE    = 8'b00000_000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, idex_dren, ex_redirect;
  logic        exmem_dren, exmem_dwen, exmem_halt;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halt;
  logic [3:0]  s_stall_cnt;

  logic [7:0]  w_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  assign w_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush};

  pipeline_ctrl #(.CNTW(16)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ex_redirect(ex_redirect), .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .exmem_halt(exmem_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNTW(4)) u_dut_small (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ex_redirect(ex_redirect), .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .exmem_halt(exmem_halt), .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .halt(s_halt),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit        = 1'b1;
    dhit        = 1'b0;
    idex_dren   = 1'b0;
    ex_redirect = 1'b0;
    exmem_dren  = 1'b0;
    exmem_dwen  = 1'b0;
    exmem_halt  = 1'b0;
    ifid_rs     = 5'd0;
    ifid_rt     = 5'd0;
    idex_rt     = 5'd0;
  endtask

  // Move to the next cycle: inputs change just after the rising edge
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();

    // Reset
    @(posedge CLK);
    @(posedge CLK);
    sample();
    check("rst_ctl", 32'(w_ctl), 32'(c_RESET));
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    RST = 1'b0;
    sample();
    check("run_ctl", 32'(w_ctl), 32'(c_NORMAL));

    // Load-use on rs
    next_cycle();
    idex_dren = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    sample();
    check("lu_rs_ctl", 32'(w_ctl), 32'(c_LOADUSE));
    next_cycle();
    idle_inputs();
    sample();
    check("lu_after_ctl", 32'(w_ctl), 32'(c_NORMAL));
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    // Load of $0 never stalls
    next_cycle();
    idex_dren = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    sample();
    check("lu_r0_ctl", 32'(w_ctl), 32'(c_NORMAL));

    // Redirect overrides load-use
    next_cycle();
    idex_dren = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ex_redirect = 1'b1;
    sample();
    check("redir_ctl", 32'(w_ctl), 32'(c_REDIR));
    check("redir_cnt_prev", 32'(stall_cnt), 32'd1);
    next_cycle();
    idle_inputs();
    sample();
    check("redir_cnt", 32'(stall_cnt), 32'd1);

    // Data miss for 3 cycles with a redirect waiting in EX
    next_cycle();
    exmem_dren = 1'b1; dhit = 1'b0;
    sample();
    check("dmiss0_ctl", 32'(w_ctl), 32'(c_FREEZE));
    next_cycle();
    ex_redirect = 1'b1;
    sample();
    check("dmiss1_ctl", 32'(w_ctl), 32'(c_FREEZE));
    check("dmiss1_cnt", 32'(stall_cnt), 32'd2);
    next_cycle();
    sample();
    check("dmiss2_ctl", 32'(w_ctl), 32'(c_FREEZE));
    next_cycle();
    dhit = 1'b1;
    sample();
    check("dhit_ctl", 32'(w_ctl), 32'(c_REDIR));
    check("dhit_cnt", 32'(stall_cnt), 32'd4);
    next_cycle();
    idle_inputs();
    sample();
    check("post_dmiss_ctl", 32'(w_ctl), 32'(c_NORMAL));
    check("post_dmiss_cnt", 32'(stall_cnt), 32'd4);

    // Load-use on rt
    next_cycle();
    idex_dren = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd5;
    sample();
    check("lu_rt_ctl", 32'(w_ctl), 32'(c_LOADUSE));

    // Instruction miss
    next_cycle();
    idle_inputs();
    ihit = 1'b0;
    sample();
    check("imiss_ctl", 32'(w_ctl), 32'(c_IMISS));
    check("imiss_cnt_prev", 32'(stall_cnt), 32'd5);
    next_cycle();
    ihit = 1'b1;
    sample();
    check("imiss_cnt", 32'(stall_cnt), 32'd6);

    // Halt arriving with a data hit: halt wins
    next_cycle();
    exmem_halt = 1'b1; exmem_dren = 1'b1; dhit = 1'b1;
    sample();
    check("haltreq_ctl", 32'(w_ctl), 32'(c_HALTREQ));
    check("haltreq_halt", 32'(halt), 32'd0);
    next_cycle();
    idle_inputs();
    sample();
    check("drain_ctl", 32'(w_ctl), 32'(c_DRAIN));
    check("drain_halt", 32'(halt), 32'd0);
    check("drain_cnt", 32'(stall_cnt), 32'd7);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      ihit        = 1'($urandom);
      dhit        = 1'($urandom);
      idex_dren   = 1'($urandom);
      ex_redirect = 1'($urandom);
      exmem_dren  = 1'($urandom);
      exmem_halt  = 1'($urandom);
      idex_rt     = 5'($urandom);
      ifid_rs     = idex_rt;
      sample();
      check("halted_ctl", 32'(w_ctl), 32'(c_IDLE));
      check("halted_halt", 32'(halt), 32'd1);
      check("halted_cnt", 32'(stall_cnt), 32'd7);
    end

    // Reset clears halt
    next_cycle();
    idle_inputs();
    RST = 1'b1;
    sample();
    check("rst2_ctl", 32'(w_ctl), 32'(c_RESET));
    next_cycle();
    RST = 1'b0;
    sample();
    check("rst2_halt", 32'(halt), 32'd0);
    check("rst2_cnt", 32'(stall_cnt), 32'd0);
    check("rst2_ctl_run", 32'(w_ctl), 32'(c_NORMAL));

    // Reset in the middle of DWAIT
    next_cycle();
    exmem_dwen = 1'b1;
    next_cycle();
    sample();
    check("dwait_ctl", 32'(w_ctl), 32'(c_FREEZE));
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    idle_inputs();
    sample();
    check("rst_dwait_ctl", 32'(w_ctl), 32'(c_NORMAL));
    check("rst_dwait_cnt", 32'(stall_cnt), 32'd0);

    // Saturation of the 4-bit counter under a long I-miss
    next_cycle();
    ihit = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      sample();
      check("sat_small_cnt", 32'(s_stall_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    check("sat_wide_cnt", 32'(stall_cnt), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
